// File: rtl/add_mul_pkg.sv
// Shared constants and types for the add_mul 5/3 lifting kernel.
package add_mul_pkg;

  localparam int W_DEF = 24;

  localparam logic STEP_PREDICT = 1'b0;
  localparam logic STEP_UPDATE  = 1'b1;
  localparam logic DIR_INV      = 1'b0;
  localparam logic DIR_FWD      = 1'b1;

  typedef logic signed [W_DEF-1:0] sample_t;

endpackage

// File: rtl/add_mul_lift_round.sv
// Stage-2 lifting term: shift/round, add or subtract against the centre sample,
// then wrap or saturate to W bits (saturation when ADD_MUL_SAT_EN is defined).
module lift_round
  import add_mul_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W+1:0] i_s,
  input  logic [W-1:0] i_c,
  input  logic         i_p,
  input  logic         i_fwd_res,
  output logic [W-1:0] o_d
);

  logic signed [W+1:0] w_s;
  logic signed [W+1:0] w_t;
  logic signed [W+1:0] w_c_ext;
  logic signed [W+1:0] w_sum;
  logic                w_sub;

  assign w_s     = $signed(i_s);
  assign w_c_ext = $signed({{2{i_c[W-1]}}, i_c});

  // The update rounding constant is already folded into s by stage 1.
  assign w_t   = (i_p == STEP_UPDATE) ? (w_s >>> 2) : (w_s >>> 1);
  assign w_sub = (i_fwd_res == DIR_FWD) ^ (i_p == STEP_UPDATE);
  assign w_sum = w_sub ? (w_c_ext - w_t) : (w_c_ext + w_t);

`ifdef ADD_MUL_SAT_EN
  logic w_fits;

  // The sum fits in W bits when its top three bits are all copies of the sign.
  assign w_fits = (w_sum[W+1:W-1] == 3'b000) || (w_sum[W+1:W-1] == 3'b111);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    o_d = w_sum[W-1:0];
    if (!w_fits) begin
      o_d = w_sum[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  logic w_unused_hi;

  assign w_unused_hi = ^w_sum[W+1:W];
  assign o_d         = w_sum[W-1:0];
`endif

endmodule

// File: rtl/add_mul.sv
// add_mul: two-stage pipelined 5/3 lifting step (predict/update, forward/inverse).
// Optional macro ADD_MUL_SAT_EN saturates d3 instead of wrapping.
module add_mul
  import add_mul_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] d3,
  output logic [W-1:0] a2,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
  input  logic [W-1:0] x4,
  input  logic [W-1:0] x5,
  input  logic         p,
  input  logic         odd_even,
  input  logic         fwd_res
);

  logic [W-1:0] w_c;
  logic [W-1:0] w_l;
  logic [W-1:0] w_r;
  logic [W+1:0] w_s;
  logic [W+1:0] w_rnd;
  logic [W-1:0] w_d;

  logic [W+1:0] r_s;
  logic [W-1:0] r_c;
  logic         r_p;
  logic         r_fwd_res;

  always_comb begin
    w_c = x3;
    w_l = x2;
    w_r = x4;
    if (odd_even) begin
      w_c = x4;
      w_l = x3;
      w_r = x5;
    end
  end

  assign w_rnd = (p == STEP_UPDATE) ? (W+2)'(2) : '0;
  assign w_s   = {{2{w_l[W-1]}}, w_l} + {{2{w_r[W-1]}}, w_r} + w_rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s       <= '0;
      r_c       <= '0;
      r_p       <= STEP_PREDICT;
      r_fwd_res <= DIR_INV;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      r_s       <= w_s;
      r_c       <= w_c;
      r_p       <= p;
      r_fwd_res <= fwd_res;
    end
  end

  lift_round #(.W(W)) u_lift_round (
    .i_s       (r_s),
    .i_c       (r_c),
    .i_p       (r_p),
    .i_fwd_res (r_fwd_res),
    .o_d       (w_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d3 <= '0;
      a2 <= '0;
    end else begin
      d3 <= w_d;
      a2 <= r_c;
    end
  end

endmodule

// File: tb/tb_add_mul.sv
// Directed self-checking bench for add_mul with hand-computed expected values.
module tb_add_mul;
  import add_mul_pkg::*;

  logic    clk;
  logic    rst_n;
  sample_t d3, a2, x2, x3, x4, x5;
  logic    p, odd_even, fwd_res;

  int checks   = 0;
  int failures = 0;

  add_mul #(.W(W_DEF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d3       (d3),
    .a2       (a2),
    .x2       (x2),
    .x3       (x3),
    .x4       (x4),
    .x5       (x5),
    .p        (p),
    .odd_even (odd_even),
    .fwd_res  (fwd_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input sample_t obs, input sample_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input sample_t v2, input sample_t v3, input sample_t v4,
                       input sample_t v5, input logic voe, input logic vp, input logic vf);
    x2 = v2; x3 = v3; x4 = v4; x5 = v5;
    odd_even = voe; p = vp; fwd_res = vf;
  endtask

  // Apply one vector and hold it for the full two-cycle latency.
  task automatic apply(input sample_t v2, input sample_t v3, input sample_t v4,
                       input sample_t v5, input logic voe, input logic vp, input logic vf);
    drive(v2, v3, v4, v5, voe, vp, vf);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(sample_t'($urandom), sample_t'($urandom), sample_t'($urandom),
          sample_t'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    repeat (3) @(posedge clk);
    #1;
    check("reset_d3", d3, 24'h000000);
    check("reset_a2", a2, 24'h000000);
    rst_n = 1'b1;

    apply(80, 120, 164, 0, 1'b0, STEP_PREDICT, DIR_FWD);
    check("fwd_pred_d3", d3, 24'hFFFFFE);
    check("fwd_pred_a2", a2, 24'd120);

    apply(164, 164, 164, 164, 1'b0, STEP_PREDICT, DIR_FWD);
    check("fwd_pred_flat_d3", d3, 24'd0);
    check("fwd_pred_flat_a2", a2, 24'd164);

    apply(80, 120, 164, 0, 1'b0, STEP_UPDATE, DIR_FWD);
    check("fwd_upd_d3", d3, 24'h0000B5);

    apply(164, 164, 164, 164, 1'b0, STEP_UPDATE, DIR_FWD);
    check("fwd_upd_flat_d3", d3, 24'd246);

    apply(80, -2, 164, 0, 1'b0, STEP_PREDICT, DIR_INV);
    check("inv_pred_d3", d3, 24'd120);
    check("inv_pred_a2", a2, 24'hFFFFFE);

    apply(7, 120, 164, 164, 1'b1, STEP_PREDICT, DIR_FWD);
    check("odd_win_d3", d3, 24'd22);
    check("odd_win_a2", a2, 24'd164);

    apply(24'h800000, 24'h7FFFFF, 24'h800000, 0, 1'b0, STEP_PREDICT, DIR_FWD);
`ifdef ADD_MUL_SAT_EN
    check("ovf_d3", d3, 24'h7FFFFF);
`else
    check("ovf_d3", d3, 24'hFFFFFF);
`endif
    check("ovf_a2", a2, 24'h7FFFFF);

    // Back-to-back control changes, one vector per cycle.
    drive(80, 120, 164, 0, 1'b0, STEP_PREDICT, DIR_FWD);
    @(posedge clk); #1;
    drive(80, 120, 164, 0, 1'b0, STEP_UPDATE, DIR_FWD);
    @(posedge clk); #1;
    check("b2b_fwd_pred", d3, 24'hFFFFFE);
    drive(80, 120, 164, 0, 1'b0, STEP_PREDICT, DIR_INV);
    @(posedge clk); #1;
    check("b2b_fwd_upd", d3, 24'd181);
    drive(80, 120, 164, 0, 1'b0, STEP_UPDATE, DIR_INV);
    @(posedge clk); #1;
    check("b2b_inv_pred", d3, 24'd242);
    @(posedge clk); #1;
    check("b2b_inv_upd", d3, 24'd59);

    // Asynchronous reset in the middle of a cycle.
    apply(80, 120, 164, 0, 1'b0, STEP_UPDATE, DIR_FWD);
    check("pre_areset_d3", d3, 24'd181);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_d3", d3, 24'd0);
    check("areset_a2", a2, 24'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_release_flush_d3", d3, 24'd0);
    @(posedge clk); #1;
    check("post_release_valid_d3", d3, 24'd181);
    check("post_release_valid_a2", a2, 24'd120);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
